// File: rtl/btn_gesture_dec.sv
// btn_gesture_dec: classifies debounced button press/release pulses into short press, long press
// and double click gestures, timed in tick_ce sample ticks. Latency: every output is registered and
// appears one clk after its deciding event. There is no backpressure; each output is a 1-clk pulse.
//
// Ports:
//   clk, rst           - system clock, synchronous active-high reset
//   en                 - decoder enable; low holds the FSM in IDLE and silences outputs
//   tick_ce            - 1-cycle sample enable at CE_HZ
//   press_pulse        - 1-cycle debounced press event
//   release_pulse      - 1-cycle debounced release event
//   short_pulse        - single short press recognised
//   long_pulse         - hold reached LONG_TICKS
//   double_pulse       - double click recognised
//   repeat_pulse       - auto-repeat while held long (constant 0 unless enabled)
//   state_o            - FSM state, for debug
//
// Optional feature macro: BTN_GESTURE_REPEAT_EN enables auto-repeat in LONG_HELD every REPEAT_TICKS.

module btn_gesture_dec #(
    parameter int CE_HZ     = 1000,
    parameter int LONG_MS   = 800,
    parameter int DCLICK_MS = 250,
    parameter int REPEAT_MS = 200,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick_ce,
    input  logic       press_pulse,
    input  logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       double_pulse,
    output logic       repeat_pulse,
    output logic [2:0] state_o
);

    localparam int LONG_TICKS_I   = LONG_MS * CE_HZ / 1000;
    localparam int DCLICK_TICKS_I = DCLICK_MS * CE_HZ / 1000;
    localparam int REPEAT_TICKS_I = REPEAT_MS * CE_HZ / 1000;

    // Elaboration-time range checks on the derived tick counts.
    if (LONG_TICKS_I < 1 || LONG_TICKS_I >= (1 << CNT_W)) begin : g_bad_long
        $error("btn_gesture_dec: LONG_TICKS out of range");
    end
    if (DCLICK_TICKS_I < 1 || DCLICK_TICKS_I >= (1 << CNT_W)) begin : g_bad_dclick
        $error("btn_gesture_dec: DCLICK_TICKS out of range");
    end
    if (REPEAT_TICKS_I < 1 || REPEAT_TICKS_I >= (1 << CNT_W)) begin : g_bad_repeat
        $error("btn_gesture_dec: REPEAT_TICKS out of range");
    end

    // Thresholds are compared against cnt+1, which needs one extra bit.
    localparam logic [CNT_W:0] LONG_T   = (CNT_W+1)'(LONG_TICKS_I);
    localparam logic [CNT_W:0] DCLICK_T = (CNT_W+1)'(DCLICK_TICKS_I);
`ifdef BTN_GESTURE_REPEAT_EN
    localparam logic [CNT_W:0] REPEAT_T = (CNT_W+1)'(REPEAT_TICKS_I);
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DOWN1     = 3'd1,
        WAIT2     = 3'd2,
        DOWN2     = 3'd3,
        LONG_HELD = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W:0]     cnt_inc;
    logic               short_q, short_d;
    logic               long_q, long_d;
    logic               double_q, double_d;
    logic               repeat_q, repeat_d;
    logic               tick_hit_long, tick_hit_dclick;

    assign cnt_inc         = {1'b0, cnt_q} + 1'b1;
    assign tick_hit_long   = tick_ce && (cnt_inc == LONG_T);
    assign tick_hit_dclick = tick_ce && (cnt_inc == DCLICK_T);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        repeat_d = 1'b0;

        // Saturating tick counter; state changes below override this with a clear.
        if (tick_ce && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_inc[CNT_W-1:0];
        end

        // Press/release are tested before the tick thresholds, so an edge landing on a
        // threshold tick wins over the timeout.
        case (state_q)
            IDLE: begin
                if (press_pulse) state_d = DOWN1;
            end
            DOWN1: begin
                if (release_pulse) begin
                    state_d = WAIT2;
                end else if (tick_hit_long) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                end
            end
            WAIT2: begin
                if (press_pulse) begin
                    state_d = DOWN2;
                end else if (tick_hit_dclick) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
            end
            DOWN2: begin
                if (release_pulse) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            LONG_HELD: begin
                if (release_pulse) begin
                    state_d = IDLE;
                end
`ifdef BTN_GESTURE_REPEAT_EN
                else if (tick_ce && (cnt_inc == REPEAT_T)) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            repeat_q <= repeat_d;
        end
    end

    assign short_pulse  = short_q;
    assign long_pulse   = long_q;
    assign double_pulse = double_q;
    assign repeat_pulse = repeat_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_btn_gesture_dec.sv
// tb_btn_gesture_dec: directed checks of btn_gesture_dec with LONG=20, DCLICK=10, REPEAT=5 ticks,
// one tick_ce every 10 clk. Latency: n/a (bench). Backpressure: n/a.
// Define BTN_GESTURE_REPEAT_EN for both files to exercise the auto-repeat scenario.

module tb_btn_gesture_dec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       tick_ce = 1'b0;
    logic       press_pulse = 1'b0;
    logic       release_pulse = 1'b0;
    logic       short_pulse, long_pulse, double_pulse, repeat_pulse;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-scenario pulse tallies, gathered after every clock.
    int  n_short, n_long, n_double, n_repeat, n_multi, n_nz;
    bit  mon_zero = 1'b0;

    btn_gesture_dec #(
        .CE_HZ(1000), .LONG_MS(20), .DCLICK_MS(10), .REPEAT_MS(5), .CNT_W(16)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .tick_ce(tick_ce),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .short_pulse(short_pulse),
        .long_pulse(long_pulse),
        .double_pulse(double_pulse),
        .repeat_pulse(repeat_pulse),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_tally();
        n_short = 0; n_long = 0; n_double = 0; n_repeat = 0; n_multi = 0; n_nz = 0;
    endtask

    // One clk cycle with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic p, input logic r, input logic t);
        press_pulse   = p;
        release_pulse = r;
        tick_ce       = t;
        @(posedge clk);
        #1;
        press_pulse   = 1'b0;
        release_pulse = 1'b0;
        tick_ce       = 1'b0;
        if (short_pulse)  n_short++;
        if (long_pulse)   n_long++;
        if (double_pulse) n_double++;
        if (repeat_pulse) n_repeat++;
        if (int'(short_pulse) + int'(long_pulse) + int'(double_pulse) + int'(repeat_pulse) > 1)
            n_multi++;
        if (mon_zero && state_o != 3'd0) n_nz++;
    endtask

    // n tick periods: 9 quiet cycles then a tick_ce cycle.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (9) cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        clear_tally();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check_eq("rst_state", state_o, 0);
        check_eq("rst_outs", {short_pulse, long_pulse, double_pulse, repeat_pulse}, 0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);                 // release in IDLE is ignored
        check_eq("idle_release_ignored", state_o, 0);

        // 1: short press
        clear_tally();
        cyc(1'b1, 1'b0, 1'b0);
        check_eq("s1_down1", state_o, 1);
        ticks(5);
        cyc(1'b0, 1'b1, 1'b0);
        check_eq("s1_wait2", state_o, 2);
        ticks(9);
        check_eq("s1_no_short_early", n_short, 0);
        ticks(1);
        check_eq("s1_short_now", short_pulse, 1);
        check_eq("s1_idle", state_o, 0);
        ticks(3);
        check_eq("s1_short_cnt", n_short, 1);
        check_eq("s1_other_cnt", n_long + n_double + n_repeat, 0);

        // 2: long press, hold 30 ticks
        clear_tally();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(19);
        check_eq("s2_no_long_early", n_long, 0);
        check_eq("s2_still_down1", state_o, 1);
        ticks(1);
        check_eq("s2_long_now", long_pulse, 1);
        check_eq("s2_long_held", state_o, 4);
        ticks(10);
        cyc(1'b0, 1'b1, 1'b0);
        check_eq("s2_idle", state_o, 0);
        ticks(15);
        check_eq("s2_long_cnt", n_long, 1);
        check_eq("s2_short_cnt", n_short + n_double, 0);
`ifdef BTN_GESTURE_REPEAT_EN
        check_eq("s2_repeat_cnt", n_repeat, 2);
`else
        check_eq("s2_repeat_cnt", n_repeat, 0);
`endif

        // 3: double click with a long second hold
        clear_tally();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(3);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(4);
        cyc(1'b1, 1'b0, 1'b0);
        check_eq("s3_down2", state_o, 3);
        ticks(50);
        check_eq("s3_still_down2", state_o, 3);
        cyc(1'b0, 1'b1, 1'b0);
        check_eq("s3_double_now", double_pulse, 1);
        check_eq("s3_idle", state_o, 0);
        ticks(15);
        check_eq("s3_double_cnt", n_double, 1);
        check_eq("s3_other_cnt", n_short + n_long + n_repeat, 0);

        // 4: release on the long threshold tick, press on the dclick timeout tick
        clear_tally();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(19);
        repeat (9) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        check_eq("s4_wait2", state_o, 2);
        check_eq("s4_no_long", long_pulse, 0);
        ticks(9);
        repeat (9) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        check_eq("s4_down2", state_o, 3);
        check_eq("s4_no_short", short_pulse, 0);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(2);
        check_eq("s4_double_cnt", n_double, 1);
        check_eq("s4_short_long_cnt", n_short + n_long, 0);

`ifdef BTN_GESTURE_REPEAT_EN
        // 5: auto-repeat while held 32 ticks
        clear_tally();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(20);
        check_eq("s5_long_now", long_pulse, 1);
        ticks(4);
        check_eq("s5_no_rep_early", n_repeat, 0);
        ticks(1);
        check_eq("s5_rep1_now", repeat_pulse, 1);
        ticks(5);
        check_eq("s5_rep2_now", repeat_pulse, 1);
        ticks(2);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(10);
        check_eq("s5_repeat_cnt", n_repeat, 2);
        check_eq("s5_long_cnt", n_long, 1);
`endif

        // 6a: reset mid-hold discards the gesture
        clear_tally();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(3);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        mon_zero = 1'b1;
        check_eq("s6_rst_state", state_o, 0);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(25);
        mon_zero = 1'b0;
        check_eq("s6_rst_nonzero_state", n_nz, 0);
        check_eq("s6_rst_pulses", n_short + n_long + n_double + n_repeat, 0);

        // 6b: en drop mid-hold discards the gesture
        clear_tally();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(3);
        en = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        en = 1'b1;
        mon_zero = 1'b1;
        check_eq("s6_en_state", state_o, 0);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(25);
        mon_zero = 1'b0;
        check_eq("s6_en_nonzero_state", n_nz, 0);
        check_eq("s6_en_pulses", n_short + n_long + n_double + n_repeat, 0);
        check_eq("onehot_outputs", n_multi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
